// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helper for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 8;
  localparam int unsigned FIFO_DEF_DEPTH = 8;

  // Ceiling log2; usable in parameter and port width expressions.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [fifo_clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [fifo_clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH     = FIFO_DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [WIDTH-1:0]            data_in,
  output logic [WIDTH-1:0]            data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [fifo_clog2(DEPTH):0]  count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned AW = fifo_clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             wr_acc_c;
  logic             rd_acc_c;

  // A read frees a slot on the same edge, so a full FIFO still accepts a write.
  assign rd_acc_c = rd_en && !empty;
  assign wr_acc_c = wr_en && (!full || rd_acc_c);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_c),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en && !wr_acc_c;
      underflow <= rd_en && !rd_acc_c;
    end
  end

  // Flags decode the count register only; no path from the request inputs.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : rdata;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_acc_c) begin
      data_out <= rdata;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (8x8 and 16x32 instances).
module tb_sync_fifo_param;

  logic        clk;
  logic        rst_n;

  logic        wr_en, rd_en;
  logic [7:0]  data_in, data_out;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  logic        wr16, rd16;
  logic [31:0] din16, dout16;
  logic        full16, empty16, af16, ae16, ovf16, udf16;
  logic [4:0]  count16;

  int n_checks;
  int n_errors;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(
    .WIDTH(32), .DEPTH(16)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr16), .rd_en(rd16),
    .data_in(din16), .data_out(dout16), .full(full16), .empty(empty16),
    .almost_full(af16), .almost_empty(ae16), .count(count16),
    .overflow(ovf16), .underflow(udf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Standard mode shows the word just popped; FWFT shows the new head.
  function automatic logic [31:0] rd_exp(input logic [31:0] popped, input logic [31:0] next_head);
`ifdef SYNC_FIFO_FWFT_EN
    return next_head;
`else
    return popped;
`endif
  endfunction

  function automatic logic [31:0] w16(input int idx);
    return 32'hC0DE_0000 + 32'(idx);
  endfunction

  task automatic step8(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step16(input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    wr16 = w; rd16 = r; din16 = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_en = 0; rd_en = 0; data_in = '0;
    wr16 = 0; rd16 = 0; din16 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
    check("rst_dout", 32'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fill 0x01..0x08, then one rejected write
    for (int i = 1; i <= 8; i++) begin
      step8(1, 0, 8'(i));
      check($sformatf("s1_count%0d", i), 32'(count), 32'(i));
      check($sformatf("s1_ae%0d", i), 32'(almost_empty), 32'(i <= 2));
      check($sformatf("s1_af%0d", i), 32'(almost_full), 32'(i >= 6));
      check($sformatf("s1_full%0d", i), 32'(full), 32'(i == 8));
      if (i == 1) check("s1_dout_first", 32'(data_out), rd_exp(0, 1));
    end
    step8(1, 0, 8'hAB);
    check("s1_ovf", 32'(overflow), 1);
    check("s1_ovf_count", 32'(count), 8);
    step8(0, 0, 8'h00);
    check("s1_ovf_clear", 32'(overflow), 0);

    // 2: drain all eight, then one rejected read
    for (int i = 1; i <= 8; i++) begin
      step8(0, 1, 8'h00);
      check($sformatf("s2_dout%0d", i), 32'(data_out), rd_exp(32'(i), (i < 8) ? 32'(i + 1) : 0));
      check($sformatf("s2_count%0d", i), 32'(count), 32'(8 - i));
    end
    check("s2_empty", 32'(empty), 1);
    step8(0, 1, 8'h00);
    check("s2_udf", 32'(underflow), 1);
    check("s2_udf_dout", 32'(data_out), rd_exp(8, 0));
    step8(0, 0, 8'h00);
    check("s2_udf_clear", 32'(underflow), 0);

    // 3: simultaneous read/write while full
    for (int i = 1; i <= 8; i++) step8(1, 0, 8'(i));
    for (int k = 0; k < 4; k++) begin
      step8(1, 1, 8'(8'h10 + k));
      check($sformatf("s3_rw_count%0d", k), 32'(count), 8);
      check($sformatf("s3_rw_ovf%0d", k), 32'(overflow), 0);
      check($sformatf("s3_rw_dout%0d", k), 32'(data_out), rd_exp(32'(1 + k), 32'(2 + k)));
    end
    seq = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h10, 8'h11, 8'h12, 8'h13};
    for (int i = 0; i < 8; i++) begin
      step8(0, 1, 8'h00);
      check($sformatf("s3_drain%0d", i), 32'(data_out), rd_exp(32'(seq[i]), (i < 7) ? 32'(seq[i + 1]) : 0));
    end
    check("s3_empty", 32'(empty), 1);

    // 4: read+write on empty
    step8(1, 1, 8'h55);
    check("s4_udf", 32'(underflow), 1);
    check("s4_count", 32'(count), 1);
    check("s4_dout", 32'(data_out), rd_exp(8'h13, 8'h55));
    step8(0, 1, 8'h00);
    check("s4_read", 32'(data_out), rd_exp(8'h55, 0));
    check("s4_udf_clear", 32'(underflow), 0);
    check("s4_empty", 32'(empty), 1);

    // 5: asynchronous reset between clock edges
    for (int i = 0; i < 5; i++) step8(1, 0, 8'(8'h20 + i));
    step8(0, 0, 8'h00);
    check("s5_pre_count", 32'(count), 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_count", 32'(count), 0);
    check("s5_rst_empty", 32'(empty), 1);
    check("s5_rst_dout", 32'(data_out), 0);
    #1 rst_n = 1'b1;
    step8(1, 0, 8'h77);
    check("s5_wr_count", 32'(count), 1);
    step8(0, 1, 8'h00);
    check("s5_rd_dout", 32'(data_out), rd_exp(8'h77, 0));
    check("s5_rd_empty", 32'(empty), 1);

`ifdef SYNC_FIFO_FWFT_EN
    // 6: fall-through head view
    step8(1, 0, 8'hA1);
    check("s6_head", 32'(data_out), 8'hA1);
    step8(0, 0, 8'h00);
    check("s6_hold", 32'(data_out), 8'hA1);
    step8(0, 1, 8'h00);
    check("s6_pop_empty", 32'(empty), 1);
    check("s6_pop_dout", 32'(data_out), 0);
`endif

    // 16x32 instance: fill, overflow, wrap both pointers, drain
    for (int i = 0; i < 16; i++) begin
      step16(1, 0, w16(i));
      check($sformatf("w_count%0d", i), 32'(count16), 32'(i + 1));
      check($sformatf("w_af%0d", i), 32'(af16), 32'(i + 1 >= 14));
      check($sformatf("w_full%0d", i), 32'(full16), 32'(i == 15));
    end
    step16(1, 0, 32'hDEAD_BEEF);
    check("w_ovf", 32'(ovf16), 1);
    check("w_ovf_count", 32'(count16), 16);
    for (int j = 0; j < 40; j++) begin
      step16(1, 1, w16(16 + j));
      check($sformatf("w_rw_dout%0d", j), dout16, rd_exp(w16(j), w16(j + 1)));
      check($sformatf("w_rw_count%0d", j), 32'(count16), 16);
    end
    for (int j = 40; j < 56; j++) begin
      step16(0, 1, 32'h0);
      check($sformatf("w_drain%0d", j), dout16, rd_exp(w16(j), (j < 55) ? w16(j + 1) : 0));
    end
    check("w_empty", 32'(empty16), 1);
    check("w_udf", 32'(udf16), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next generation of the team's 8x8 sync_fifo.
- Generalised in width, depth and almost-full/almost-empty thresholds.
- Adds write-overflow and read-underflow error pulses, simultaneous read/write at full, and a compile-time first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in the same clock domain as the standard elastic buffer.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset; single clock domain, reset asynchronous and active-low
wr_en  input  1  write request
rd_en  input  1  read request
data_in  input  WIDTH  write data, sampled with accepted write
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write requested and rejected
underflow  output  1  one-cycle pulse: read requested and rejected

Behaviour:
- Reset (rst_n low, async assert, sync release on clk edge):
  - wr_ptr, rd_ptr, count, overflow, underflow and data_out all 0.
  - empty=1, almost_empty=1, full=0; almost_full=0 (AF_THRESH>=1).
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate register, not a pointer difference.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en && (!full || rd_acc)
  - rd_acc = rd_en && !empty
- Full with wr_en and rd_en both high: both accepted; count unchanged; oldest word read, new word written.
- Empty with wr_en and rd_en both high: write accepted, read rejected; underflow pulses; count becomes 1.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Flags (full, empty, almost_*) are combinational decodes of the count register only, with no path from wr_en/rd_en. They therefore change on the same edge as count.
- overflow = registered (wr_en && !wr_acc); underflow = registered (rd_en && !rd_acc). Each is high for exactly one cycle per rejected request. A rejected request changes no other state.
- Standard read mode:
  - data_out is registered; it loads mem[rd_ptr] on the edge where rd_acc=1.
  - Data is visible the cycle after the rd_en cycle (1-cycle latency).
  - data_out holds its value otherwise, including after an underflow.
- Reset mid-operation: all pointers and flags return to reset values immediately, regardless of clk; any in-flight transfer is discarded.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN
- Defined:
  - data_out = mem[rd_ptr] whenever !empty (0-latency head view); rd_en acts as a pop/acknowledge of the displayed word.
  - A word written into an empty FIFO appears on data_out the cycle after its write edge, when empty deasserts.
  - data_out is 0 while empty.
  - Accept rules and flags are identical to standard mode.
- Undefined: standard registered read with 1-cycle latency, as in Behaviour.

Decomposition:
- Package sync_fifo_pkg:
  - clog2-style function for pointer/count widths.
  - default constants FIFO_DEF_WIDTH=8, FIFO_DEF_DEPTH=8.
- Sub-module fifo_mem:
  - DEPTH x WIDTH storage.
  - synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata), so the same array serves both read modes.
- Pointer, count, flag and error logic stay in sync_fifo_param.

Test Plan:
(WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2 unless stated)
1. Reset, then write 0x01..0x08 on consecutive cycles:
   - count steps 1..8; almost_empty drops when count=3; almost_full rises at count=6; full=1 at count=8.
   - A 9th write of 0xAB gives overflow=1 for one cycle; count stays 8.
2. Drain 8 reads from full:
   - Standard mode: data_out=0x01..0x08, each one cycle after its rd_en.
   - empty=1 after the 8th read; a 9th rd_en gives underflow=1 for one cycle and data_out holds 0x08.
3. Fill to 8, then hold wr_en=rd_en=1 for 4 cycles with data 0x10..0x13:
   - count stays 8; no overflow; reads return 0x01..0x04.
   - Final drain returns 0x05..0x08 then 0x10..0x13.
4. From empty, wr_en=rd_en=1 with data 0x55:
   - underflow=1; count=1; the next read returns 0x55.
5. Write 5 words, assert rst_n=0 between clock edges:
   - count=0, empty=1, data_out=0 immediately, without waiting for a clk edge.
   - After release, the first write/read returns the new data with no stale words.
6. Build with SYNC_FIFO_FWFT_EN, write 0xA1:
   - data_out=0xA1 the cycle after the write, with no rd_en.
   - A rd_en pop leaves empty=1 and data_out=0.
   - Also rerun scenario 1 with DEPTH=16, WIDTH=32 and wrap pointers twice.
